mac_seq_ctrl: RTL

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// Sequential multiply-accumulate controller for one LSTM neuron: walks N operand
// pairs, adds the bias, saturates the result and hands it to the activation stage.
module mac_seq_ctrl #(
    parameter int NUM      = 45,
    parameter int NUM_LSTM = 8,
    parameter int WIDTH    = 32,
    parameter int FRAC     = 24
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_start,
    input  logic                               i_upd,
    input  logic                               i_clr,
    input  logic [WIDTH-1:0]                   i_k,
    input  logic [WIDTH-1:0]                   i_w,
    input  logic [WIDTH-1:0]                   i_b,
    output logic [$clog2(NUM+NUM_LSTM)-1:0]    o_addr,
    output logic                               o_busy,
    output logic                               o_done,
    output logic [WIDTH-1:0]                   o_sum,
    output logic                               o_wr
);

    localparam int N     = NUM + NUM_LSTM;
    localparam int AW    = $clog2(N);
    localparam int ACC_W = WIDTH + 8;
    localparam int PW    = 2 * WIDTH;
    localparam int EW    = 2 * WIDTH + 2;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    localparam logic signed [EW-1:0] ACC_MAX = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EW-1:0] ACC_MIN = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [EW-1:0] OUT_MAX = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] OUT_MIN = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

    state_t state;
    state_t next_state;

    logic signed [ACC_W-1:0] acc;
    logic signed [PW-1:0]    k_ext;
    logic signed [PW-1:0]    w_ext;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    prod_sh;
    logic signed [EW-1:0]    mac_sum;
    logic signed [EW-1:0]    bias_sum;
    logic signed [ACC_W-1:0] mac_sat;
    logic signed [WIDTH-1:0] bias_sat;

    assign k_ext   = {{WIDTH{i_k[WIDTH-1]}}, i_k};
    assign w_ext   = {{WIDTH{i_w[WIDTH-1]}}, i_w};
    assign prod    = k_ext * w_ext;
    assign prod_sh = prod >>> FRAC;

    // The accumulator clamps instead of wrapping so a long run of large
    // products still lands on the correct saturation rail after the bias.
    assign mac_sum  = {{(EW-ACC_W){acc[ACC_W-1]}}, acc} + {{(EW-PW){prod_sh[PW-1]}}, prod_sh};
    assign bias_sum = {{(EW-ACC_W){acc[ACC_W-1]}}, acc} + {{(EW-WIDTH){i_b[WIDTH-1]}}, i_b};

    assign mac_sat  = (mac_sum > ACC_MAX)  ? ACC_MAX[ACC_W-1:0] :
                      (mac_sum < ACC_MIN)  ? ACC_MIN[ACC_W-1:0] : mac_sum[ACC_W-1:0];
    assign bias_sat = (bias_sum > OUT_MAX) ? OUT_MAX[WIDTH-1:0] :
                      (bias_sum < OUT_MIN) ? OUT_MIN[WIDTH-1:0] : bias_sum[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (i_clr) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_start) next_state = MAC;
                MAC:     if (o_addr == LAST) next_state = BIAS;
                BIAS:    next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = (state != IDLE);
        o_done = (state == DONE);
    end

    // Write-back strobe is registered, so it always lands in an idle cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            o_addr <= '0;
            o_sum  <= '0;
            o_wr   <= 1'b0;
        end else begin
            o_wr <= (state == IDLE) && i_upd && !i_start && !i_clr;
            if (i_clr) begin
                o_addr <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            acc    <= '0;
                            o_addr <= '0;
                        end
                    end
                    MAC: begin
                        acc    <= mac_sat;
                        o_addr <= (o_addr == LAST) ? '0 : o_addr + AW'(1);
                    end
                    BIAS:    o_sum <= bias_sat;
                    default: ;
                endcase
            end
        end
    end

endmodule
